// File: rtl/cla_pkg.sv
// Shared definitions for the shared-CLA-adder controller and its arbiter.
package cla_pkg;

    localparam int unsigned DEFAULT_N       = 8;
    localparam int unsigned DEFAULT_R       = 4;
    localparam int unsigned DEFAULT_ADD_LAT = 1;

    // Width needed to hold indices 0..value-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    localparam int unsigned ID_W = clog2(DEFAULT_R);

    // Tag travelling alongside an in-flight add for the default configuration.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/cla_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves past the granted requester only when advance is high.
module cla_rr_arbiter
    import cla_pkg::*;
#(
    parameter int unsigned R = DEFAULT_R,
    localparam int unsigned PW = clog2(R)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [R-1:0]  req_i,
    input  logic          adv_i,
    output logic [R-1:0]  grant_o,
    output logic [PW-1:0] gidx_o
);

    logic [PW-1:0] ptr_q, ptr_d;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < R; k++) begin
            idx = (32'(ptr_q) + k) % R;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                gidx_o       = PW'(idx);
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = PW'((32'(gidx_o) + 1) % R);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cla_add_share_ctrl.sv
// Shares one registered CLA adder among R requesters. Operands are issued
// through registers, the requester id rides a tag pipe matched to the adder
// latency, and each sum comes back as a one-cycle one-hot pulse.
module cla_add_share_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned N       = DEFAULT_N,
    parameter int unsigned R       = DEFAULT_R,
    parameter int unsigned ADD_LAT = DEFAULT_ADD_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    input  logic [N:0]     add_sum,
    output logic [R-1:0]   rsp_valid,
    output logic [N:0]     rsp_sum,
    output logic           busy
);

    localparam int unsigned RID_W = clog2(R);
    localparam int unsigned DEPTH = 1 + ADD_LAT;

    // Tag sized for this instance's requester count.
    typedef struct packed {
        logic             valid;
        logic [RID_W-1:0] id;
    } slot_t;

    logic [R-1:0]     arb_req;
    logic [R-1:0]     grant;
    logic [RID_W-1:0] gidx;
    logic             hs;

    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    slot_t            tag_q [DEPTH];
    slot_t            tag_in;
    logic [R-1:0]     rsp_valid_q, rsp_valid_d;
    logic [N:0]       rsp_sum_q, rsp_sum_d;

    // Requests are masked during reset so nothing can be accepted then.
    assign arb_req   = reset ? '0 : req_valid;
    assign req_ready = grant;
    assign hs        = |(req_valid & grant);

    cla_rr_arbiter #(
        .R(R)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (arb_req),
        .adv_i   (hs),
        .grant_o (grant),
        .gidx_o  (gidx)
    );

    // Operand mux: granted slice on handshake, otherwise hold.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        for (int unsigned i = 0; i < R; i++) begin
            if (grant[i]) begin
                a_d = req_a[i*N +: N];
                b_d = req_b[i*N +: N];
            end
        end
        tag_in.valid = hs;
        tag_in.id    = gidx;
    end

    // Issue registers feeding the shared adder.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Tag pipe: stage 0 is the issue stage, last stage lines up with add_sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Response capture when the tag pipe delivers a valid tag.
    always_comb begin
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        if (tag_q[DEPTH-1].valid) begin
            rsp_valid_d[tag_q[DEPTH-1].id] = 1'b1;
            rsp_sum_d                      = add_sum;
        end
    end

    // Response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    // Busy while any tag stage holds a live op.
    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            busy = busy | tag_q[k].valid;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;

endmodule
